framemask_scheduler: RTL and testbench

- Stores the 112x112 pixel capture mask in a word-organised RAM that the APB bridge writes.
- Once per frame, scans the mask in raster order and issues each selected (row, col) to the Stonyman readout controller over a valid/ready handshake.
- Sits between the APB register file and the Stonyman controller, so readout skips unmasked pixels.
- Bypass mode captures every pixel.

---
 rtl/framemask_pkg.sv | 41 ++++
 rtl/framemask_scheduler_if.sv | 30 +++
 rtl/framemask_ram.sv | 26 ++
 rtl/framemask_scheduler.sv | 159 +++++++++++++++
 tb/tb_framemask_scheduler.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/framemask_pkg.sv
// Shared geometry, widths and FSM encoding for the frame-mask readout scheduler.
// Mask RAM words are addressed row*WORDS_PER_ROW + word_col.
package framemask_pkg;

  localparam int unsigned RESOLUTION    = 112;
  localparam int unsigned WORD_W        = 16;
  localparam int unsigned WORDS_PER_ROW = RESOLUTION / WORD_W;
  localparam int unsigned MASK_WORDS    = RESOLUTION * WORDS_PER_ROW;

  localparam int unsigned ROW_W  = 7;
  localparam int unsigned COL_W  = 7;
  localparam int unsigned WCOL_W = 3;
  localparam int unsigned BIT_W  = 4;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned CNT_W  = 14;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    LOAD,
    SCAN,
    EMIT,
    DONE
  } state_e;

  // Index of the least significant set bit; 0 when the word is empty.
  function automatic logic [BIT_W-1:0] lowest_set(input logic [WORD_W-1:0] w);
    logic [BIT_W-1:0] b;
    logic             found;
    b     = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < WORD_W; i++) begin
      if (!found && w[i]) begin
        b     = BIT_W'(i);
        found = 1'b1;
      end
    end
    return b;
  endfunction

endpackage

// File: rtl/framemask_scheduler_if.sv
// Bus bundle between the APB mask writer / frame control and the Stonyman pixel handshake.
// master drives writes, frame control and pix_ready; slave is the scheduler.
interface framemask_scheduler_if;
  import framemask_pkg::*;

  logic                write_enable;
  logic [ADDR_W-1:0]   addr;
  logic [WORD_W-1:0]   data;
  logic                mask_enable;
  logic                frame_start;
  logic                abort;
  logic                pix_valid;
  logic                pix_ready;
  logic [ROW_W-1:0]    pix_row;
  logic [COL_W-1:0]    pix_col;
  logic                busy;
  logic                frame_done;
  logic [CNT_W-1:0]    pix_count;

  modport master (
    output write_enable, addr, data, mask_enable, frame_start, abort, pix_ready,
    input  pix_valid, pix_row, pix_col, busy, frame_done, pix_count
  );

  modport slave (
    input  write_enable, addr, data, mask_enable, frame_start, abort, pix_ready,
    output pix_valid, pix_row, pix_col, busy, frame_done, pix_count
  );

endinterface

// File: rtl/framemask_ram.sv
// 784x16 simple dual-port mask RAM: one write port, one registered read port.
// A same-address write and read in one cycle returns the previous contents.
module framemask_ram
  import framemask_pkg::*;
(
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [MASK_WORDS];

  always_ff @(posedge clk) begin
    if (we_i && (waddr_i < ADDR_W'(MASK_WORDS))) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_o <= mem_q[raddr_i];
    end
  end

endmodule

// File: rtl/framemask_scheduler.sv
// Once per frame, walks the capture mask in raster order and hands each selected
// (row, col) to the Stonyman readout controller over a valid/ready handshake.
module framemask_scheduler
  import framemask_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  framemask_scheduler_if.slave bus
);

  state_e             state_q, state_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [WCOL_W-1:0]  wcol_q, wcol_d;
  logic [ADDR_W-1:0]  waddr_q, waddr_d;
  logic [WORD_W-1:0]  work_q, work_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [ROW_W-1:0]   pix_row_q, pix_row_d;
  logic [COL_W-1:0]   pix_col_q, pix_col_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               men_q, men_d;

  logic               ram_re;
  logic [WORD_W-1:0]  ram_rdata;
  logic               last_word;
  logic               wcol_last;
  logic [BIT_W-1:0]   enc_bit;

  framemask_ram u_ram (
    .clk     (clk),
    .we_i    (bus.write_enable),
    .waddr_i (bus.addr),
    .wdata_i (bus.data),
    .re_i    (ram_re),
    .raddr_i (waddr_q),
    .rdata_o (ram_rdata)
  );

  assign wcol_last = (wcol_q == WCOL_W'(WORDS_PER_ROW - 1));
  assign last_word = wcol_last && (row_q == ROW_W'(RESOLUTION - 1));
  assign enc_bit   = lowest_set(work_q);

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; abort outranks everything, including a start in IDLE
  always_comb begin
    state_d = state_q;
    if (bus.abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (bus.frame_start) state_d = READ;
        READ: state_d = LOAD;
        LOAD: state_d = SCAN;
        SCAN: begin
          if (work_q != '0)   state_d = EMIT;
          else if (last_word) state_d = DONE;
          else                state_d = READ;
        end
        EMIT: if (bus.pix_ready) state_d = SCAN;
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    bus.pix_valid  = (state_q == EMIT);
    bus.busy       = (state_q != IDLE);
    bus.frame_done = (state_q == DONE);
    ram_re         = (state_q == READ);
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_q     <= '0;
      wcol_q    <= '0;
      waddr_q   <= '0;
      work_q    <= '0;
      bit_q     <= '0;
      pix_row_q <= '0;
      pix_col_q <= '0;
      cnt_q     <= '0;
      men_q     <= 1'b0;
    end else begin
      row_q     <= row_d;
      wcol_q    <= wcol_d;
      waddr_q   <= waddr_d;
      work_q    <= work_d;
      bit_q     <= bit_d;
      pix_row_q <= pix_row_d;
      pix_col_q <= pix_col_d;
      cnt_q     <= cnt_d;
      men_q     <= men_d;
    end
  end

  // Word address runs alongside row/word_col so no multiply is needed
  always_comb begin
    row_d     = row_q;
    wcol_d    = wcol_q;
    waddr_d   = waddr_q;
    work_d    = work_q;
    bit_d     = bit_q;
    pix_row_d = pix_row_q;
    pix_col_d = pix_col_q;
    cnt_d     = cnt_q;
    men_d     = men_q;
    if (!bus.abort) begin
      unique case (state_q)
        IDLE: begin
          if (bus.frame_start) begin
            row_d   = '0;
            wcol_d  = '0;
            waddr_d = '0;
            cnt_d   = '0;
            men_d   = bus.mask_enable;
          end
        end
        LOAD: work_d = men_q ? ram_rdata : '1;
        SCAN: begin
          if (work_q != '0) begin
            bit_d     = enc_bit;
            pix_row_d = row_q;
            pix_col_d = {wcol_q, enc_bit};
          end else if (!last_word) begin
            waddr_d = waddr_q + ADDR_W'(1);
            if (wcol_last) begin
              wcol_d = '0;
              row_d  = row_q + ROW_W'(1);
            end else begin
              wcol_d = wcol_q + WCOL_W'(1);
            end
          end
        end
        EMIT: begin
          if (bus.pix_ready) begin
            work_d = work_q & ~(WORD_W'(1) << bit_q);
            cnt_d  = cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.pix_row   = pix_row_q;
  assign bus.pix_col   = pix_col_q;
  assign bus.pix_count = cnt_q;

endmodule

// File: tb/tb_framemask_scheduler.sv
// Scoreboard bench for framemask_scheduler: stimulus queues expected pixels and
// checks; a negedge monitor pops and compares them.
module tb_framemask_scheduler;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  framemask_scheduler_if bus ();

  framemask_scheduler dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string name;
    int    act;
    int    exp;
  } chk_t;

  chk_t chk_q[$];
  int   exp_q[$];
  int   rise_q[$];

  int   errors   = 0;
  int   checks   = 0;
  int   done_cnt = 0;
  int   done_cyc = 0;
  logic prev_v   = 1'b0;
  chk_t mon_c;
  int   mon_e;
  int   mon_a;

  always @(negedge clk) begin
    while (chk_q.size() > 0) begin
      mon_c = chk_q.pop_front();
      checks++;
      if (mon_c.act != mon_c.exp) begin
        errors++;
        $display("FAIL %s: got %0d expected %0d", mon_c.name, mon_c.act, mon_c.exp);
      end
    end
    if (rst_n) begin
      if (bus.pix_valid && !prev_v) rise_q.push_back(cyc);
      if (bus.pix_valid && bus.pix_ready) begin
        checks++;
        mon_a = int'(bus.pix_row) * 256 + int'(bus.pix_col);
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pixel: got (%0d,%0d) expected none", bus.pix_row, bus.pix_col);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_a != mon_e) begin
            errors++;
            $display("FAIL pixel: got (%0d,%0d) expected (%0d,%0d)",
                     bus.pix_row, bus.pix_col, mon_e / 256, mon_e % 256);
          end
        end
      end
      if (bus.frame_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
    prev_v = bus.pix_valid;
  end

  task automatic check(input string n, input int a, input int e);
    chk_t c;
    c.name = n;
    c.act  = a;
    c.exp  = e;
    chk_q.push_back(c);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_word(input int a, input int d);
    bus.write_enable = 1'b1;
    bus.addr         = 10'(a);
    bus.data         = 16'(d);
    tick(1);
    bus.write_enable = 1'b0;
  endtask

  task automatic start_frame(output int c0);
    bus.frame_start = 1'b1;
    c0 = cyc;
    tick(1);
    bus.frame_start = 1'b0;
  endtask

  task automatic push_sparse();
    exp_q.push_back(0 * 256 + 0);
    exp_q.push_back(1 * 256 + 31);
  endtask

  task automatic wait_until_valid(input string n, input int budget);
    int k;
    k = 0;
    while (!bus.pix_valid && k < budget) begin
      tick(1);
      k++;
    end
    check(n, int'(bus.pix_valid), 1);
  endtask

  task automatic wait_until_count(input string n, input int target, input int budget);
    int k;
    k = 0;
    while (int'(bus.pix_count) != target && k < budget) begin
      tick(1);
      k++;
    end
    check(n, int'(bus.pix_count), target);
  endtask

  task automatic finish_frame(input string n, input int c0, input int n0,
                              input int exp_rel, input int exp_cnt);
    int k;
    k = 0;
    while (done_cnt == n0 && k < 40000) begin
      tick(1);
      k++;
    end
    tick(3);
    check({n, "_done_pulses"}, done_cnt - n0, 1);
    if (exp_rel >= 0) check({n, "_done_cycle"}, done_cyc - c0, exp_rel);
    check({n, "_pix_count"}, int'(bus.pix_count), exp_cnt);
    check({n, "_pixels_left"}, exp_q.size(), 0);
    check({n, "_busy"}, int'(bus.busy), 0);
  endtask

  int c0, n0, r0;

  initial begin
    bus.write_enable = 1'b0;
    bus.addr         = '0;
    bus.data         = '0;
    bus.mask_enable  = 1'b1;
    bus.frame_start  = 1'b0;
    bus.abort        = 1'b0;
    bus.pix_ready    = 1'b1;

    tick(3);
    check("rst_pix_valid", int'(bus.pix_valid), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_frame_done", int'(bus.frame_done), 0);
    check("rst_pix_row", int'(bus.pix_row), 0);
    check("rst_pix_col", int'(bus.pix_col), 0);
    check("rst_pix_count", int'(bus.pix_count), 0);
    rst_n = 1'b1;
    tick(2);

    // Bypass: every pixel, 2 cycles each on top of the 2353-cycle word walk
    bus.mask_enable = 1'b0;
    for (int r = 0; r < 112; r++)
      for (int c = 0; c < 112; c++) exp_q.push_back(r * 256 + c);
    n0 = done_cnt;
    r0 = rise_q.size();
    start_frame(c0);
    finish_frame("bypass", c0, n0, 2353 + 2 * 12544, 12544);
    check("bypass_first_valid", rise_q[r0] - c0, 4);

    // Empty mask, plus an out-of-range write that must not land anywhere
    bus.mask_enable = 1'b1;
    for (int a = 0; a < 784; a++) write_word(a, 0);
    write_word(800, 16'hFFFF);
    n0 = done_cnt;
    start_frame(c0);
    finish_frame("empty", c0, n0, 2353, 0);

    // Sparse mask; mask_enable drop and a second frame_start mid-frame are ignored
    write_word(0, 16'h0001);
    write_word(8, 16'h8000);
    push_sparse();
    n0 = done_cnt;
    r0 = rise_q.size();
    start_frame(c0);
    bus.mask_enable = 1'b0;
    tick(6);
    check("busy_mid_frame", int'(bus.busy), 1);
    bus.frame_start = 1'b1;
    tick(1);
    bus.frame_start = 1'b0;
    finish_frame("sparse", c0, n0, 2357, 2);
    check("sparse_first_valid", rise_q[r0] - c0, 4);
    bus.mask_enable = 1'b1;

    // Back-pressure: ready low for 10 cycles of pix_valid, accepted on the 11th
    bus.pix_ready = 1'b0;
    push_sparse();
    n0 = done_cnt;
    r0 = rise_q.size();
    start_frame(c0);
    @(negedge clk);
    for (int k = 0; k < 50 && !bus.pix_valid; k++) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      check("stall_valid", int'(bus.pix_valid), 1);
      check("stall_row", int'(bus.pix_row), 0);
      check("stall_col", int'(bus.pix_col), 0);
      check("stall_count", int'(bus.pix_count), 0);
      if (i < 9) @(negedge clk);
    end
    @(posedge clk);
    #1;
    bus.pix_ready = 1'b1;
    tick(1);
    check("stall_count_after_accept", int'(bus.pix_count), 1);
    finish_frame("stall", c0, n0, 2367, 2);
    check("stall_first_valid", rise_q[r0] - c0, 4);

    // Abort while the second pixel is pending
    exp_q.push_back(0);
    n0 = done_cnt;
    start_frame(c0);
    wait_until_count("abort_first_accept", 1, 50);
    bus.pix_ready = 1'b0;
    wait_until_valid("abort_second_valid", 3000);
    bus.abort = 1'b1;
    tick(1);
    bus.abort = 1'b0;
    check("abort_pix_valid", int'(bus.pix_valid), 0);
    check("abort_busy", int'(bus.busy), 0);
    check("abort_pix_count", int'(bus.pix_count), 1);
    tick(2500);
    check("abort_no_done", done_cnt - n0, 0);

    // abort and frame_start together in IDLE: nothing starts
    bus.abort       = 1'b1;
    bus.frame_start = 1'b1;
    tick(1);
    bus.abort       = 1'b0;
    bus.frame_start = 1'b0;
    check("abort_start_busy0", int'(bus.busy), 0);
    tick(1);
    check("abort_start_busy1", int'(bus.busy), 0);

    bus.pix_ready = 1'b1;
    push_sparse();
    n0 = done_cnt;
    start_frame(c0);
    finish_frame("after_abort", c0, n0, 2357, 2);

    // Asynchronous reset while (1,31) is pending
    exp_q.push_back(0);
    start_frame(c0);
    wait_until_count("rstemit_first_accept", 1, 50);
    bus.pix_ready = 1'b0;
    wait_until_valid("rstemit_valid", 3000);
    check("rstemit_pre_row", int'(bus.pix_row), 1);
    check("rstemit_pre_col", int'(bus.pix_col), 31);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstemit_pix_valid", int'(bus.pix_valid), 0);
    check("rstemit_busy", int'(bus.busy), 0);
    check("rstemit_pix_row", int'(bus.pix_row), 0);
    check("rstemit_pix_col", int'(bus.pix_col), 0);
    check("rstemit_pix_count", int'(bus.pix_count), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(2);
    bus.pix_ready = 1'b1;
    push_sparse();
    n0 = done_cnt;
    r0 = rise_q.size();
    start_frame(c0);
    finish_frame("post_reset", c0, n0, 2357, 2);
    check("post_reset_first_valid", rise_q[r0] - c0, 4);

    tick(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
